// File: rtl/starsoc_params.sv
// starsoc_params: shared definitions for the StarSoC display path.
//   sprite_t        - sprite register layout at the display-path default widths
//   cfg_field_e     - configuration field select encodings
//   COLOR_*         - 12-bit RGB444 palette constants
package starsoc_params;

    localparam int unsigned SPR_COORD_W = 10;
    localparam int unsigned SPR_SIZE_W  = 6;
    localparam int unsigned SPR_COLOR_W = 12;

    typedef struct packed {
        logic                   en;
        logic [SPR_COORD_W-1:0] px;
        logic [SPR_COORD_W-1:0] py;
        logic [SPR_SIZE_W-1:0]  w;
        logic [SPR_SIZE_W-1:0]  h;
        logic [SPR_COLOR_W-1:0] color;
    } sprite_t;

    typedef enum logic [1:0] {
        CFG_POS   = 2'd0,
        CFG_SIZE  = 2'd1,
        CFG_COLOR = 2'd2,
        CFG_EN    = 2'd3
    } cfg_field_e;

    localparam logic [11:0] COLOR_BLACK  = 12'h000;
    localparam logic [11:0] COLOR_RED    = 12'hF00;
    localparam logic [11:0] COLOR_GREEN  = 12'h0F0;
    localparam logic [11:0] COLOR_BLUE   = 12'h00F;
    localparam logic [11:0] COLOR_CYAN   = 12'h0FF;
    localparam logic [11:0] COLOR_YELLOW = 12'hFF0;
    localparam logic [11:0] COLOR_WHITE  = 12'hFFF;

endpackage

// File: rtl/sprite_hit.sv
// sprite_hit: combinational bounds test of one pixel against one sprite.
//   en, px, py, w, h - sprite enable, top-left corner and size
//   x, y             - pixel under test
//   hit              - pixel lies inside the sprite rectangle
module sprite_hit #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned SIZE_W  = 6
) (
    input  logic               en,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [SIZE_W-1:0]  w,
    input  logic [SIZE_W-1:0]  h,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               hit
);

    localparam int unsigned SUM_W = COORD_W + 1;

    // One extra bit so a sprite running past the screen edge clips instead of wrapping.
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    assign x_end = {1'b0, px} + SUM_W'(w);
    assign y_end = {1'b0, py} + SUM_W'(h);

    // A zero width/height makes the end equal the start, so nothing can hit.
    assign hit = en
               && (x >= px) && ({1'b0, x} < x_end)
               && (y >= py) && ({1'b0, y} < y_end);

endmodule

// File: rtl/sprite_gen.sv
// sprite_gen: multi-sprite pixel generator with double-buffered sprite registers.
//   clk, reset          - clock, asynchronous active-high reset
//   p_tick, x, y,
//   video_on            - pixel strobe and the pixel it qualifies
//   vsync               - rising edge swaps pending -> active bank
//   cfg_we, cfg_idx,
//   cfg_field, cfg_data - pending-bank write port
//   rgb_out, pix_valid  - pixel colour two cycles after p_tick
//   collision           - last frame's overlaps with sprite 0 (bit 0 always 0)
//   frame_start         - pulses once per bank swap
module sprite_gen
    import starsoc_params::*;
#(
    parameter int unsigned        NUM_SPRITES = 4,
    parameter int unsigned        COORD_W     = 10,
    parameter int unsigned        SIZE_W      = 6,
    parameter int unsigned        COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] BG_COLOR    = COLOR_W'(COLOR_BLACK)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           p_tick,
    input  logic [COORD_W-1:0]             x,
    input  logic [COORD_W-1:0]             y,
    input  logic                           video_on,
    input  logic                           vsync,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_SPRITES)-1:0] cfg_idx,
    input  logic [1:0]                     cfg_field,
    input  logic [2*COORD_W-1:0]           cfg_data,
    output logic [COLOR_W-1:0]             rgb_out,
    output logic                           pix_valid,
    output logic [NUM_SPRITES-1:0]         collision,
    output logic                           frame_start
);

    localparam int unsigned      IDX_W   = $clog2(NUM_SPRITES);
    localparam logic [IDX_W:0]   NUM_IDX = NUM_SPRITES[IDX_W:0];

    // Pending bank (cfg writes) and active bank (rendering)
    logic [NUM_SPRITES-1:0] pend_en, act_en;
    logic [COORD_W-1:0]     pend_px    [NUM_SPRITES];
    logic [COORD_W-1:0]     pend_py    [NUM_SPRITES];
    logic [SIZE_W-1:0]      pend_w     [NUM_SPRITES];
    logic [SIZE_W-1:0]      pend_h     [NUM_SPRITES];
    logic [COLOR_W-1:0]     pend_color [NUM_SPRITES];
    logic [COORD_W-1:0]     act_px     [NUM_SPRITES];
    logic [COORD_W-1:0]     act_py     [NUM_SPRITES];
    logic [SIZE_W-1:0]      act_w      [NUM_SPRITES];
    logic [SIZE_W-1:0]      act_h      [NUM_SPRITES];
    logic [COLOR_W-1:0]     act_color  [NUM_SPRITES];

    logic vsync_q;
    logic armed;
    logic swap;
    logic idx_ok;

    // armed stays low for the first clock after reset so a vsync that is
    // already high at release is recorded in vsync_q rather than seen as an edge.
    assign swap   = vsync && !vsync_q && armed;
    assign idx_ok = ({1'b0, cfg_idx} < NUM_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q     <= 1'b0;
            armed       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            armed       <= 1'b1;
            frame_start <= swap;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_en    <= '0;
            pend_px    <= '{default: '0};
            pend_py    <= '{default: '0};
            pend_w     <= '{default: '0};
            pend_h     <= '{default: '0};
            pend_color <= '{default: '0};
        end else if (cfg_we && idx_ok) begin
            case (cfg_field)
                CFG_POS: begin
                    pend_px[cfg_idx] <= cfg_data[COORD_W-1:0];
                    pend_py[cfg_idx] <= cfg_data[2*COORD_W-1:COORD_W];
                end
                CFG_SIZE: begin
                    pend_w[cfg_idx] <= cfg_data[SIZE_W-1:0];
                    pend_h[cfg_idx] <= cfg_data[2*SIZE_W-1:SIZE_W];
                end
                CFG_COLOR: pend_color[cfg_idx] <= cfg_data[COLOR_W-1:0];
                CFG_EN:    pend_en[cfg_idx]    <= cfg_data[0];
                default: ;
            endcase
        end
    end

    // The swap copies the pending bank as it stood before this cycle's write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_en    <= '0;
            act_px    <= '{default: '0};
            act_py    <= '{default: '0};
            act_w     <= '{default: '0};
            act_h     <= '{default: '0};
            act_color <= '{default: '0};
        end else if (swap) begin
            act_en    <= pend_en;
            act_px    <= pend_px;
            act_py    <= pend_py;
            act_w     <= pend_w;
            act_h     <= pend_h;
            act_color <= pend_color;
        end
    end

    logic [NUM_SPRITES-1:0] hit;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit #(
            .COORD_W (COORD_W),
            .SIZE_W  (SIZE_W)
        ) u_hit (
            .en  (act_en[g]),
            .px  (act_px[g]),
            .py  (act_py[g]),
            .w   (act_w[g]),
            .h   (act_h[g]),
            .x   (x),
            .y   (y),
            .hit (hit[g])
        );
    end

    // Collision: overlaps with sprite 0 on sampled visible pixels.
    // A sample on the swap cycle seeds the new frame's vector.
    logic [NUM_SPRITES-1:0] coll_hit;
    logic [NUM_SPRITES-1:0] live;

    assign coll_hit = (p_tick && video_on && hit[0]) ? {hit[NUM_SPRITES-1:1], 1'b0} : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live      <= '0;
            collision <= '0;
        end else if (swap) begin
            collision <= live;
            live      <= coll_hit;
        end else begin
            live      <= live | coll_hit;
        end
    end

    // Stage 1: snapshot of hits and colours, so a later swap cannot touch this pixel.
    logic [NUM_SPRITES-1:0] s1_hit;
    logic [COLOR_W-1:0]     s1_color [NUM_SPRITES];
    logic                   s1_video;
    logic                   s1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_hit   <= '0;
            s1_color <= '{default: '0};
            s1_video <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            s1_hit   <= hit;
            s1_color <= act_color;
            s1_video <= video_on;
            s1_valid <= p_tick;
        end
    end

    // Lowest index wins.
    logic [COLOR_W-1:0] pix_color;
    logic               found;

    always_comb begin
        pix_color = BG_COLOR;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (s1_hit[i] && !found) begin
                pix_color = s1_color[i];
                found     = 1'b1;
            end
        end
        if (!s1_video) begin
            pix_color = '0;
        end
    end

    // Stage 2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_out   <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= s1_valid;
            if (s1_valid) begin
                rgb_out <= pix_color;
            end
        end
    end

endmodule

// File: doc/sprite_gen.md
# sprite_gen

Parametrised multi-sprite pixel generator for the StarSoC display path. Holds NUM_SPRITES rectangular sprites, each with a position, size, colour and enable, written through a configuration port. Given the current pixel from the HDMI timing block, it produces the colour of the highest-priority covering sprite, or the background colour. Sprite registers are double-buffered and swap at frame start to avoid tearing, and a per-frame collision vector against sprite 0 (the player ship) is reported to game logic.

## Interface
Parameters:
- NUM_SPRITES, 4, number of sprites; legal range 2..16
- COORD_W, 10, width of pixel coordinates and sprite positions
- SIZE_W, 6, width of sprite width/height fields
- COLOR_W, 12, pixel colour width
- BG_COLOR, COLOR_BLACK, colour driven in the visible area where no sprite covers the pixel

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- p_tick  in  1  pixel strobe; x/y/video_on are valid and sampled in this cycle
- x  in  COORD_W  current pixel column
- y  in  COORD_W  current pixel row
- video_on  in  1  high in the visible area
- vsync  in  1  level from timing block; its rising edge marks frame start
- cfg_we  in  1  configuration write strobe; always accepted, no backpressure
- cfg_idx  in  $clog2(NUM_SPRITES)  target sprite
- cfg_field  in  2  field select: 0 = position {y,x}, 1 = size {h,w}, 2 = colour, 3 = enable (bit 0)
- cfg_data  in  2*COORD_W  write data, LSB-aligned per field
- rgb_out  out  COLOR_W  registered pixel colour
- pix_valid  out  1  pulses when rgb_out has been updated for a sampled pixel
- collision  out  NUM_SPRITES  per-frame collision of sprite k with sprite 0; bit 0 is always 0
- frame_start  out  1  one-cycle pulse on the cycle the buffers swap

## Operation
- Two register banks per sprite:
  - The pending bank is written by cfg_we.
  - The active bank is used for rendering.
- Frame swap:
  - vsync is registered once; a rising edge is vsync & ~vsync_q.
  - On that cycle the active bank is loaded from pending, and frame_start pulses.
  - A cfg write in the same cycle updates pending only and takes effect at the next swap.
- Hit test for sprite k (active bank):
  - en_k && x >= px_k && x < px_k+w_k && y >= py_k && y < py_k+h_k.
  - Sums are computed in COORD_W+1 bits, so a sprite crossing coordinate 2^COORD_W clips and does not wrap.
  - w = 0 or h = 0 never hits.
- Priority: the lowest index wins. Sprite 0 is drawn over all others.
- Colour selection:
  - video_on = 0: 0 (blanking).
  - Otherwise: the winning sprite's colour, or BG_COLOR if no sprite hits.
- Collision:
  - A live vector accumulates during the frame. Bit k (k ≥ 1) is set on any sampled pixel with video_on, hit_0 and hit_k all high.
  - At swap, collision <= live and live is cleared.
  - A hit sampled on the swap cycle itself goes into the new live vector.
- Out-of-range cfg_idx (≥ NUM_SPRITES) is ignored.

## Timing
- Two-stage pipeline that advances every clk cycle:
  - Stage 1 registers the hit vector, the colour candidates and video_on, plus a valid bit equal to p_tick.
  - Stage 2 registers the priority-muxed colour into rgb_out.
- Latency: the p_tick sample in cycle n produces rgb_out and pix_valid in cycle n+2. rgb_out holds its value between updates.
- Rendering in stages 1–2 uses the active bank as it stood when stage 1 sampled. A swap never alters a pixel already in flight.
- Reset values:
  - rgb_out = 0, pix_valid = 0, collision = 0, frame_start = 0.
  - Both banks zero, so all sprites are disabled.
  - live = 0, vsync_q = 0.
- Reset asserted mid-frame: all state clears immediately. The first swap occurs on the first vsync rising edge after release; a vsync already high at release does not count as an edge.

## Structure
- starsoc_params holds:
  - the sprite_t packed struct {en, px, py, w, h, color};
  - the cfg field encodings CFG_POS/CFG_SIZE/CFG_COLOR/CFG_EN;
  - the existing COLOR_* constants.
- Sub-module sprite_hit: one sprite's combinational bounds compare, instantiated NUM_SPRITES times via generate.
- Priority mux, bank registers and collision logic live in sprite_gen.

## Test plan
- Reset then idle: drive p_tick with video_on = 1 over the whole frame -> rgb_out = BG_COLOR (12'h000) everywhere, collision = 0.
- Sprite 1 pos (100,50), size (20,40), colour CYAN, enabled; one vsync edge:
  - x = 119, y = 89 -> CYAN.
  - x = 120 or y = 90 -> BG.
  - Output appears exactly 2 cycles after p_tick.
- Sprites 0 (RED) and 2 (CYAN) overlap at (10,10): the pixel there -> RED. At the next frame swap, collision = 4'b0100.
- Rewrite sprite 1 position mid-frame: output is unchanged until the next vsync rising edge, then it moves. A write on the edge cycle is deferred one frame.
- Sprite at px = 1020, w = 20 (COORD_W = 10): x = 1023 hits, x = 0..3 do not (no wrap). w = 0 never hits.
- Assert reset mid-frame while sprite 0 covers the pixel: rgb_out goes to 0 immediately, and the sprite does not reappear after a swap until it is re-enabled.
